// File: rtl/sram_host_ctrl.sv
// Host-side sequencer for sram_top: serialises writes (shift/load/w_en) and runs reads with a response channel.
// Optional read watchdog enabled by defining SRAM_RD_TIMEOUT_EN.
module sram_host_ctrl #(
  parameter int unsigned ROWS           = 16,
  parameter int unsigned COLS           = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    srst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [$clog2(ROWS)-1:0] req_addr,
  input  logic [COLS-1:0]         req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [COLS-1:0]         rsp_data,
  output logic                    rsp_err,
  output logic                    wr_done,
  output logic                    serial_in,
  output logic                    shift,
  output logic                    load,
  output logic                    w_en,
  output logic                    r_en,
  output logic [$clog2(ROWS)-1:0] addr,
  input  logic                    data_valid,
  input  logic [COLS-1:0]         data_out
);

  localparam int unsigned AW = $clog2(ROWS);
  localparam int unsigned CW = $clog2(COLS + 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    LOAD,
    WRITE,
    READ,
    RESP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [COLS-1:0] sreg_q, sreg_d;
  logic [AW-1:0]   addr_d;
  logic [COLS-1:0] rdata_d;

`ifdef SRAM_RD_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          err_d;
`else
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    addr_d  = addr;
    rdata_d = rsp_data;
`ifdef SRAM_RD_TIMEOUT_EN
    tcnt_d  = tcnt_q;
    err_d   = rsp_err;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          cnt_d  = '0;
          if (req_we) begin
            sreg_d  = req_wdata;
            state_d = SHIFT;
          end else begin
            state_d = READ;
`ifdef SRAM_RD_TIMEOUT_EN
            tcnt_d  = '0;
`endif
          end
        end
      end
      SHIFT: begin
        // serial_in is always the shifter MSB, giving bit COLS-1-cnt each cycle
        sreg_d = sreg_q << 1;
        if (cnt_q == CW'(COLS - 1)) begin
          cnt_d   = '0;
          state_d = LOAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOAD:  state_d = WRITE;
      WRITE: state_d = IDLE;
      READ: begin
        if (data_valid) begin
          rdata_d = data_out;
          state_d = RESP;
`ifdef SRAM_RD_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
`endif
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sreg_q    <= '0;
      addr      <= '0;
      rsp_data  <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      wr_done   <= 1'b0;
      serial_in <= 1'b0;
      shift     <= 1'b0;
      load      <= 1'b0;
      w_en      <= 1'b0;
      r_en      <= 1'b0;
`ifdef SRAM_RD_TIMEOUT_EN
      tcnt_q    <= '0;
      rsp_err   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sreg_q    <= sreg_d;
      addr      <= addr_d;
      rsp_data  <= rdata_d;
      req_ready <= (state_d == IDLE);
      rsp_valid <= (state_d == RESP);
      wr_done   <= (state_d == WRITE);
      serial_in <= (state_d == SHIFT) & sreg_d[COLS-1];
      shift     <= (state_d == SHIFT);
      load      <= (state_d == LOAD);
      w_en      <= (state_d == WRITE);
      r_en      <= (state_d == READ);
`ifdef SRAM_RD_TIMEOUT_EN
      tcnt_q    <= tcnt_d;
      rsp_err   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_sram_host_ctrl.sv
// Directed self-checking bench for sram_host_ctrl with a pin-level sipo/sram behavioural model.
module tb_sram_host_ctrl;

  logic       clk = 1'b0;
  logic       srst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_we = 1'b0;
  logic [3:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       wr_done;
  logic       serial_in;
  logic       shift;
  logic       load;
  logic       w_en;
  logic       r_en;
  logic [3:0] addr;
  logic       data_valid = 1'b0;
  logic [7:0] data_out = '0;

  int tests = 0;
  int fails = 0;

  sram_host_ctrl #(
    .ROWS(16),
    .COLS(8),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk),
    .srst(srst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .wr_done(wr_done),
    .serial_in(serial_in),
    .shift(shift),
    .load(load),
    .w_en(w_en),
    .r_en(r_en),
    .addr(addr),
    .data_valid(data_valid),
    .data_out(data_out)
  );

  always #5 clk = ~clk;

  // Behavioural sipo + sram: everything it stores arrives through the DUT pins.
  logic [7:0] sipo = '0;
  logic [7:0] stage = '0;
  logic [7:0] mem [16];
  int wen_count = 0;
  int overlap = 0;

  always @(posedge clk) begin
    if (shift) sipo <= {sipo[6:0], serial_in};
    if (load) stage <= sipo;
    if (w_en) begin
      mem[addr] <= stage;
      wen_count <= wen_count + 1;
    end
    if (w_en && r_en) overlap <= overlap + 1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic we, input logic [3:0] a, input logic [7:0] d);
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL req_ready_before_req: got %b, expected 1", req_ready);
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    cyc();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    srst = 1'b1;
    repeat (2) cyc();
    srst = 1'b0;
    cyc();
    tests++;
    if ({req_ready, rsp_valid, rsp_err, wr_done, serial_in, shift, load, w_en, r_en} !== 9'b100000000 ||
        addr !== 4'd0 || rsp_data !== 8'd0) begin
      fails++;
      $display("FAIL reset_outputs: ready/rv/err/done/si/sh/ld/we/re=%b addr=%0d rsp_data=%h, expected 100000000 addr=0 rsp_data=00",
               {req_ready, rsp_valid, rsp_err, wr_done, serial_in, shift, load, w_en, r_en}, addr, rsp_data);
    end
  endtask

  task automatic test_write(input logic [3:0] a, input logic [7:0] d, input bit noise);
    do_req(1'b1, a, d);
    for (int k = 1; k <= 8; k++) begin
      tests++;
      if (shift !== 1'b1 || serial_in !== d[8-k] || req_ready !== 1'b0 || load !== 1'b0 ||
          w_en !== 1'b0 || rsp_valid !== 1'b0 || r_en !== 1'b0) begin
        fails++;
        $display("FAIL write_shift[%0d] addr=%0d: shift=%b serial_in=%b ready=%b load=%b w_en=%b rsp_valid=%b r_en=%b, expected shift=1 serial_in=%b others 0",
                 k, a, shift, serial_in, req_ready, load, w_en, rsp_valid, r_en, d[8-k]);
      end
      // data_valid outside READ must not disturb a write
      data_valid = noise && (k == 3);
      data_out   = 8'hEE;
      cyc();
    end
    data_valid = 1'b0;
    tests++;
    if (load !== 1'b1 || shift !== 1'b0 || serial_in !== 1'b0 || w_en !== 1'b0) begin
      fails++;
      $display("FAIL write_load addr=%0d: load=%b shift=%b serial_in=%b w_en=%b, expected 1 0 0 0",
               a, load, shift, serial_in, w_en);
    end
    cyc();
    tests++;
    if (w_en !== 1'b1 || wr_done !== 1'b1 || addr !== a || load !== 1'b0 || r_en !== 1'b0) begin
      fails++;
      $display("FAIL write_commit: w_en=%b wr_done=%b addr=%0d load=%b r_en=%b, expected 1 1 addr=%0d 0 0",
               w_en, wr_done, addr, load, r_en, a);
    end
    cyc();
    tests++;
    if (req_ready !== 1'b1 || w_en !== 1'b0 || wr_done !== 1'b0 || rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL write_done_idle: ready=%b w_en=%b wr_done=%b rsp_valid=%b, expected 1 0 0 0",
               req_ready, w_en, wr_done, rsp_valid);
    end
  endtask

  task automatic test_read(input logic [3:0] a, input logic [7:0] exp, input int delay, input int bp);
    do_req(1'b0, a, 8'h00);
    for (int i = 0; i <= delay; i++) begin
      tests++;
      if (r_en !== 1'b1 || addr !== a || rsp_valid !== 1'b0 || req_ready !== 1'b0 || w_en !== 1'b0) begin
        fails++;
        $display("FAIL read_wait[%0d] addr=%0d: r_en=%b addr=%0d rsp_valid=%b ready=%b w_en=%b, expected 1 %0d 0 0 0",
                 i, a, r_en, addr, rsp_valid, req_ready, w_en, a);
      end
      if (i == delay) begin
        data_valid = 1'b1;
        data_out   = mem[addr];
      end
      cyc();
    end
    data_valid = 1'b0;
    data_out   = 8'h3C;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_data !== exp || rsp_err !== 1'b0 || r_en !== 1'b0 || req_ready !== 1'b0) begin
      fails++;
      $display("FAIL read_rsp addr=%0d: rsp_valid=%b rsp_data=%h rsp_err=%b r_en=%b ready=%b, expected 1 %h 0 0 0",
               a, rsp_valid, rsp_data, rsp_err, r_en, req_ready, exp);
    end
    req_valid = (bp > 0);
    req_we    = 1'b0;
    req_addr  = a ^ 4'h1;
    for (int j = 0; j < bp; j++) begin
      cyc();
      tests++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp || req_ready !== 1'b0 || r_en !== 1'b0 || rsp_err !== 1'b0) begin
        fails++;
        $display("FAIL read_backpressure[%0d]: rsp_valid=%b rsp_data=%h ready=%b r_en=%b err=%b, expected 1 %h 0 0 0",
                 j, rsp_valid, rsp_data, req_ready, r_en, rsp_err, exp);
      end
    end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || r_en !== 1'b0) begin
      fails++;
      $display("FAIL read_handshake: rsp_valid=%b ready=%b r_en=%b, expected 0 1 0", rsp_valid, req_ready, r_en);
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset_abort();
    int w;
    w = wen_count;
    do_req(1'b1, 4'h9, 8'hFF);
    cyc();
    cyc();
    srst = 1'b1;
    repeat (3) cyc();
    srst = 1'b0;
    cyc();
    tests++;
    if ({req_ready, rsp_valid, wr_done, serial_in, shift, load, w_en, r_en} !== 8'b10000000) begin
      fails++;
      $display("FAIL reset_abort_outputs: ready/rv/done/si/sh/ld/we/re=%b, expected 10000000",
               {req_ready, rsp_valid, wr_done, serial_in, shift, load, w_en, r_en});
    end
    repeat (14) cyc();
    tests++;
    if (wen_count !== w) begin
      fails++;
      $display("FAIL reset_abort_no_wen: w_en pulses=%0d, expected %0d", wen_count, w);
    end
  endtask

  task automatic test_sweep();
    logic [3:0] a;
    for (int r = 0; r < 16; r++) begin
      a = 4'(r);
      test_write(a, {~a, a}, 1'b0);
    end
    for (int r = 0; r < 16; r++) begin
      a = 4'(r);
      test_read(a, {~a, a}, r % 3, 0);
    end
    tests++;
    if (overlap !== 0) begin
      fails++;
      $display("FAIL sweep_wen_ren_overlap: overlap cycles=%0d, expected 0", overlap);
    end
  endtask

`ifdef SRAM_RD_TIMEOUT_EN
  task automatic test_timeout();
    int bad;
    bad = 0;
    do_req(1'b0, 4'h3, 8'h00);
    for (int i = 1; i <= 64; i++) begin
      if (r_en !== 1'b1 || rsp_valid !== 1'b0) bad++;
      if (i < 64) cyc();
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL timeout_wait: %0d of 64 cycles without r_en=1/rsp_valid=0, expected 0", bad);
    end
    cyc();
    tests++;
    if (r_en !== 1'b0 || rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 8'h00) begin
      fails++;
      $display("FAIL timeout_rsp: r_en=%b rsp_valid=%b rsp_err=%b rsp_data=%h, expected 0 1 1 00",
               r_en, rsp_valid, rsp_err, rsp_data);
    end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    tests++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL timeout_handshake: ready=%b rsp_valid=%b, expected 1 0", req_ready, rsp_valid);
    end
    test_read(4'h3, 8'hC3, 2, 0);
    // data_valid in the final watchdog cycle takes priority
    do_req(1'b0, 4'h6, 8'h00);
    repeat (63) cyc();
    data_valid = 1'b1;
    data_out   = 8'h5A;
    cyc();
    data_valid = 1'b0;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== 8'h5A) begin
      fails++;
      $display("FAIL timeout_tie: rsp_valid=%b rsp_err=%b rsp_data=%h, expected 1 0 5a", rsp_valid, rsp_err, rsp_data);
    end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
  endtask
`else
  task automatic test_no_timeout();
    test_read(4'h5, 8'hA5, 100, 0);
  endtask
`endif

  initial begin
    test_reset();
    test_write(4'd5, 8'hA5, 1'b1);
    test_read(4'd5, 8'hA5, 3, 4);
    test_reset_abort();
    test_sweep();
`ifdef SRAM_RD_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_host_ctrl.md
Name: sram_host_ctrl

Overview:
Host-side command sequencer sitting directly upstream of sram_top.
- Accepts parallel write/read requests over a valid/ready handshake.
- Serialises write data onto the serial_in/shift/load pins, then fires w_en for one cycle.
- For reads, holds r_en and addr until data_valid, captures data_out and returns it on a valid/ready response channel.

Parameters:
ROWS, 16, number of SRAM words; addr width is $clog2(ROWS)
COLS, 8, word width in bits; serial shift length
TIMEOUT_CYCLES, 64, read watchdog limit (used only with SRAM_RD_TIMEOUT_EN)

Ports:
clk  input  1  single clock, all logic on posedge
srst  input  1  synchronous reset, active-high
req_valid  input  1  request present
req_ready  output  1  controller idle, request accepted when req_valid&req_ready
req_we  input  1  1=write, 0=read
req_addr  input  $clog2(ROWS)  target word
req_wdata  input  COLS  write data
rsp_valid  output  1  read response present
rsp_ready  input  1  host accepts response
rsp_data  output  COLS  read data
rsp_err  output  1  read timed out (0 when feature compiled out)
wr_done  output  1  one-cycle pulse, write committed
serial_in  output  1  to sram_top serial_in
shift  output  1  to sram_top shift
load  output  1  to sram_top load
w_en  output  1  to sram_top w_en
r_en  output  1  to sram_top r_en
addr  output  $clog2(ROWS)  to sram_top addr
data_valid  input  1  from sram_top
data_out  input  COLS  from sram_top

Behaviour:
- Clock and reset: all outputs registered; none depends combinationally on any input.
- Reset (srst=1 at posedge): state=IDLE, every output 0 except req_ready=1 from the first cycle after reset. bit counter=0, capture regs=0.
- Reset mid-operation aborts with no partial write: w_en is never asserted after a reset edge. A pending rsp is dropped.
- FSM states: IDLE, SHIFT, LOAD, WRITE, READ, RESP.
- IDLE: req_ready=1. On accept, latch req_we/addr/wdata, drop req_ready, go to SHIFT if we=1, else READ.
- SHIFT:
  - COLS consecutive cycles with shift=1.
  - serial_in = latched bit COLS-1-cnt, i.e. MSB first.
  - cnt is $clog2(COLS+1) wide and counts 0..COLS-1.
  - After the last bit, go to LOAD.
- LOAD: one cycle, load=1, shift=0, serial_in=0. Then WRITE.
- WRITE: one cycle, w_en=1, addr=latched addr, wr_done=1. Then IDLE.
- Write latency: accept at cycle T; shift T+1..T+COLS; load T+COLS+1; w_en/wr_done T+COLS+2; req_ready=1 again at T+COLS+3.
- READ:
  - r_en=1 and addr driven from T+1.
  - Held until data_valid is sampled 1; then capture data_out into rsp_data and go to RESP.
  - data_valid is ignored in every state except READ.
- RESP:
  - rsp_valid=1; rsp_data and rsp_err held stable until rsp_valid&rsp_ready, then IDLE.
  - r_en=0 in RESP.
  - req_ready=0 throughout RESP.
- Only one request is outstanding at a time. req_valid while busy is ignored (not queued).
- addr holds its last latched value between operations; w_en and r_en are never high in the same cycle.

Optional Feature:
SRAM_RD_TIMEOUT_EN
- Defined:
  - READ runs a counter from 0.
  - If data_valid has not been seen after TIMEOUT_CYCLES cycles in READ, drop r_en and go to RESP with rsp_err=1 and rsp_data=0.
  - A successful read gives rsp_err=0.
  - If data_valid and the timeout occur in the same cycle, data_valid wins (rsp_err=0).
- Not defined: READ waits indefinitely; rsp_err is tied 0 and no counter logic exists.

Test Plan:
- Reset: srst=1 for 3 cycles mid-SHIFT -> next cycle all outputs 0, req_ready=1, no w_en pulse ever observed for the aborted write.
- Write, COLS=8: addr=5, wdata=8'hA5 accepted at T -> serial_in sequence 1,0,1,0,0,1,0,1 with shift=1 on T+1..T+8, load at T+9, w_en and wr_done at T+10 with addr=5, req_ready=1 at T+11.
- Read: addr=5 after the write above, sram_top model raises data_valid with data_out=8'hA5 -> r_en held until then, rsp_valid next cycle, rsp_data=8'hA5, rsp_err=0.
- Backpressure: rsp_ready=0 for 4 cycles -> rsp_valid and rsp_data stable, req_ready=0, second req_valid not accepted until after the handshake.
- Full sweep: write ~addr pattern to all 16 rows then read back, with sram_top and sipo attached -> every rsp_data equals the written word, no w_en/r_en overlap.
- Timeout (SRAM_RD_TIMEOUT_EN, TIMEOUT_CYCLES=64): data_valid stuck 0 -> r_en falls after 64 cycles, rsp_valid=1, rsp_err=1, rsp_data=0; next request is accepted normally.
